uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-003 nRST  input  1  asynchronous active-low reset.
REQ-004 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 data  output  8  last correctly framed byte, LSB received first.
REQ-006 temp  output  7  equals data[6:0]; temperature value from the companion uart_tx.
REQ-007 valid  output  1  one-cycle pulse, new byte on data/temp.
REQ-008 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 rx shall pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 Frame format shall be 1 start (0), 8 data LSB-first, 1 stop (1), no parity.
REQ-012 States shall be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: on rx_s == 0, go to START and clear the bit-timer to 0.
REQ-014 START: when timer reaches CLKS_PER_BIT/2 - 1 (integer division), sample rx_s; if 0, clear timer, bit index = 0, go to DATA; if 1, treat as glitch, go to IDLE with no pulse.
REQ-015 DATA: when timer reaches CLKS_PER_BIT - 1, sample rx_s into shift register bit [index], clear timer, increment index; after index 7 is sampled, go to STOP.
REQ-016 STOP: when timer reaches CLKS_PER_BIT - 1, sample rx_s; if 1, load data from the shift register, pulse valid, and go to IDLE; if 0, leave data unchanged, pulse frame_err, and go to WAIT_IDLE.
REQ-017 valid and frame_err shall be registered, high for exactly the one cycle following the stop-sample edge; they shall never be high together.
REQ-018 WAIT_IDLE: remain until rx_s == 1 (break condition), then go to IDLE; no pulses while waiting.
REQ-019 A start bit beginning in the cycle immediately after return to IDLE shall be accepted (back-to-back frames, zero idle bits).
REQ-020 The timer shall be wide enough for CLKS_PER_BIT - 1 with no wrap; the index shall be 3 bits.
REQ-021 data and temp shall hold their value between frames and across framing errors.
REQ-022 Latency: valid shall rise 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1 for edge phase) after the falling edge of rx.

Reset
REQ-023 nRST low shall immediately force state IDLE, data = 0, valid = 0, frame_err = 0, busy = 0, timer = 0, index = 0, and synchronizer flops = 1.
REQ-024 Reset asserted mid-frame shall abort the frame with no pulse; after release the block shall wait for a fresh falling edge.

Verification (bench CLKS_PER_BIT = 16, 20 ns clk)
REQ-025 Send 0x48 (temp 72) with valid framing -> exactly one valid pulse, data = 0x48, temp = 72, frame_err never high.
REQ-026 Send 0x55 then 0xA3 back-to-back with no idle bit -> two valid pulses, data 0x55 then 0xA3.
REQ-027 Low glitch on rx of 4 clk cycles -> returns to IDLE, no valid, no frame_err, data unchanged.
REQ-028 Send 0x3C with stop bit 0, rx held low 3 bit times, then high -> one frame_err pulse, data keeps its prior value, busy high until rx returns high, a subsequent 0x11 is received correctly.
REQ-029 Assert nRST during bit 4 of 0x7F -> outputs reset at once, no pulse; next frame 0x01 yields data = 0x01.
REQ-030 Loopback with uart_tx (start pulsed, temp = 72) -> temp = 72 with one valid pulse.

Source files
------------

// File: rtl/uart_rx_if.sv
// Serial receive bus: the line coming in and the decoded byte/status going out.
// The slave side is the receiver; the master side is whatever drives rx and consumes results.
interface uart_rx_if;
   logic       rx;
   logic [7:0] data;
   logic [6:0] temp;
   logic       valid;
   logic       frame_err;
   logic       busy;

   modport slave  (input rx, output data, temp, valid, frame_err, busy);
   modport master (output rx, input data, temp, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, glitch rejection on the start bit,
// and break handling after a framing error.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic     clk,
   input  logic     nRST,
   uart_rx_if.slave bus
);

   localparam int unsigned TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t        r_state;
   logic [1:0]    r_sync;
   logic [TW-1:0] r_timer;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_ferr;
   logic          w_rx_s;

   assign w_rx_s = r_sync[1];

   // Synchronizer resets to the idle line level so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) r_sync <= 2'b11;
      else       r_sync <= {r_sync[0], bus.rx};
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_rx_s) begin
                  r_state <= START;
                  r_timer <= '0;
               end
            end
            START: begin
               if (r_timer == HALF) begin
                  r_timer <= '0;
                  r_idx   <= '0;
                  r_state <= w_rx_s ? IDLE : DATA;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            DATA: begin
               if (r_timer == FULL) begin
                  r_shift[r_idx] <= w_rx_s;
                  r_timer        <= '0;
                  r_idx          <= r_idx + 3'd1;
                  if (r_idx == 3'd7) r_state <= STOP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            STOP: begin
               if (r_timer == FULL) begin
                  r_timer <= '0;
                  if (w_rx_s) begin
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= WAIT_IDLE;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            WAIT_IDLE: begin
               // Line stuck low (break) after a bad stop bit: hold off until it recovers.
               if (w_rx_s) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.data      = r_data;
   assign bus.temp      = r_data[6:0];
   assign bus.valid     = r_valid;
   assign bus.frame_err = r_ferr;
   assign bus.busy      = (r_state != IDLE);

endmodule
